video_timing_src: RTL and testbench
===================================

Name: video_timing_src

Overview:
- Synthesizable, parametrised successor to the bench-side raster driver used for the filter blocks.
- Generates programmable-resolution video timing: vsync, hsync, valid, with pixel data from an external source or a built-in test pattern.
- Feeds pre_img_* inputs of processing blocks such as bilateral_filter, on-chip or in simulation.
- Adds start/stop at frame boundaries, sync polarity, pattern modes and frame counting.

Parameters:
- DATA_W, 8: pixel width.
- H_SYNC, 40: hsync length in clocks.
- H_BACK, 220: line back porch.
- H_DISP, 1280: active pixels per line.
- H_FRONT, 110: line front porch.
- V_SYNC, 5: vsync length in lines.
- V_BACK, 20: frame back porch in lines.
- V_DISP, 720: active lines.
- V_FRONT, 5: frame front porch in lines.
- SYNC_POL, 1: active level of vsync/hsync.
- CHK_SHIFT, 3: log2 of checkerboard square size.
- CNT_W, 12: width of position counters; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  run request; level-sensitive
- mode  in  2  0 external, 1 horizontal gradient, 2 checkerboard, 3 solid
- solid_val  in  DATA_W  pixel value for mode 3
- ext_data  in  DATA_W  external pixel, valid in the cycle data_req is high
- data_req  out  1  external pixel request, one cycle ahead of img_valid
- img_vsync  out  1  vertical sync
- img_hsync  out  1  horizontal sync
- img_valid  out  1  active-pixel strobe
- img_data  out  DATA_W  pixel data
- x_pos  out  CNT_W  active column of img_data, 0..H_DISP-1
- y_pos  out  CNT_W  active line of img_data, 0..V_DISP-1
- frame_start  out  1  one-cycle pulse on first cycle of each frame
- frame_cnt  out  16  completed-start frame count

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps.
- Region order per line/frame: sync, back porch, display, front porch.
- Sync and active decode (from counters):
  - vsync active while v_cnt < V_SYNC.
  - hsync active while h_cnt < H_SYNC; this holds on every line, including vsync lines.
  - active = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- data_req = active AND state==RUN AND latched mode==0. It is combinational from the counters.
- All img_* outputs, x_pos, y_pos and frame_start are registered with 1-cycle latency from counter decode.
- ext_data is sampled when data_req=1 and appears on img_data the next cycle, with img_valid=1.
- Outside active, img_data=0 and x_pos=y_pos=0.
- Pattern data, using registered-stage x/y:
  - mode 1: x mod 2^DATA_W.
  - mode 2: all-ones if ((x>>CHK_SHIFT) XOR (y>>CHK_SHIFT)) bit0 = 1, else 0.
  - mode 3: solid_val.
- mode and solid_val are latched at each frame start (h_cnt=0, v_cnt=0 in RUN). Changes mid-frame take effect next frame.
- FSM:
  - IDLE: counters held at 0; outputs inactive. Goes to RUN when enable=1. First frame_start follows one cycle later.
  - RUN: counters advance. On the last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1): if enable=0 go to IDLE, else wrap and continue.
  - enable deassert mid-frame never truncates a frame: the frame completes fully, then outputs go inactive.
- frame_start pulses on the output cycle for h_cnt=0, v_cnt=0.
- frame_cnt increments in the same cycle as frame_start and wraps 0xFFFF->0.
- Reset, including mid-frame:
  - state=IDLE; counters=0; frame_cnt=0.
  - img_valid=0, img_data=0, data_req=0, frame_start=0, x_pos=y_pos=0.
  - img_vsync=img_hsync=~SYNC_POL from the cycle after the reset edge.
- Inactive sync level is ~SYNC_POL, both in IDLE and outside sync regions.

Test Plan:
Sim params: H 2/3/8/2 (H_TOTAL 15), V 1/1/4/1 (V_TOTAL 7), DATA_W 8, CHK_SHIFT 1; one frame = 105 cycles.
- enable=1, mode=1 -> 8 valid pixels per line with data 00..07, 32 per frame; hsync 2 cycles per line; vsync 15 cycles; frame_start every 105 cycles; frame_cnt 1,2,3.
- mode=0, ext_data = incrementing byte updated on data_req -> img_data equals the value presented the prior cycle; 32 values 00..1F per frame; data_req never high when img_valid would be 0.
- mode=2 -> (x0,y0)=00, (x2,y0)=FF, (x0,y2)=FF, (x2,y2)=00; mode=3 with solid_val=5A -> all 32 pixels 5A.
- Switch mode 1->3 at line 2 of a frame -> rest of that frame stays gradient; next frame all 5A.
- Drop enable at cycle 40 of a frame -> frame runs to cycle 104, then IDLE: no further valid, syncs inactive, frame_cnt frozen. Re-enable -> frame_start next cycle, frame_cnt+1.
- SYNC_POL=0 -> syncs idle high, pulse low. Assert rst_n=0 mid-line -> next cycle all outputs at reset values; after release frame_cnt restarts from 0.

Source files
------------

// File: rtl/video_timing_src.sv
// Programmable raster timing source: sync/valid generation with external or
// built-in pattern pixel data, frame-aligned start/stop and frame counting.
module video_timing_src #(
    parameter int DATA_W    = 8,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 220,
    parameter int H_DISP    = 1280,
    parameter int H_FRONT   = 110,
    parameter int V_SYNC    = 5,
    parameter int V_BACK    = 20,
    parameter int V_DISP    = 720,
    parameter int V_FRONT   = 5,
    parameter int SYNC_POL  = 1,
    parameter int CHK_SHIFT = 3,
    parameter int CNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] solid_val,
    input  logic [DATA_W-1:0] ext_data,
    output logic              data_req,
    output logic              img_vsync,
    output logic              img_hsync,
    output logic              img_valid,
    output logic [DATA_W-1:0] img_data,
    output logic [CNT_W-1:0]  x_pos,
    output logic [CNT_W-1:0]  y_pos,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BACK + V_DISP);

    localparam logic SYNC_ACT = (SYNC_POL != 0);
    localparam logic SYNC_INA = ~SYNC_ACT;

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_GRAD  = 2'd1;
    localparam logic [1:0] MODE_CHK   = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    // Counter width must cover the full raster; catch bad parameter sets early.
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("video_timing_src: CNT_W too small for raster totals");
    end
    if (CHK_SHIFT >= CNT_W) begin : g_bad_chk
        $error("video_timing_src: CHK_SHIFT must be below CNT_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]    v_cnt_q, v_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   solid_q, solid_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                vsync_q, vsync_d;
    logic                hsync_q, hsync_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    x_q, x_d;
    logic [CNT_W-1:0]    y_q, y_d;
    logic                fs_q, fs_d;

    logic                running;
    logic                frame_first;
    logic                h_last, v_last;
    logic                h_act, v_act, active;
    logic [CNT_W-1:0]    x_cur, y_cur;
    logic [1:0]          mode_eff;
    logic [DATA_W-1:0]   solid_eff;
    logic                chk_bit;
    logic [DATA_W-1:0]   pix;

    // Counter decode
    always_comb begin
        running     = (state_q == RUN);
        frame_first = running && (h_cnt_q == '0) && (v_cnt_q == '0);
        h_last      = (h_cnt_q == H_LAST);
        v_last      = (v_cnt_q == V_LAST);
        h_act       = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
        v_act       = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
        active      = running && h_act && v_act;
        x_cur       = h_cnt_q - H_ACT_S;
        y_cur       = v_cnt_q - V_ACT_S;
        // The latch cycle itself already uses the new frame's settings.
        mode_eff    = frame_first ? mode : mode_q;
        solid_eff   = frame_first ? solid_val : solid_q;
        chk_bit     = x_cur[CHK_SHIFT] ^ y_cur[CHK_SHIFT];
    end

    assign data_req = active && (mode_eff == MODE_EXT);

    // Pixel source select
    always_comb begin
        pix = '0;
        if (active) begin
            case (mode_eff)
                MODE_EXT:   pix = ext_data;
                MODE_GRAD:  pix = DATA_W'(x_cur);
                MODE_CHK:   pix = {DATA_W{chk_bit}};
                MODE_SOLID: pix = solid_eff;
                default:    pix = '0;
            endcase
        end
    end

    // Run/idle control and raster counters
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (h_last) begin
                    h_cnt_d = '0;
                    if (v_last) begin
                        v_cnt_d = '0;
                        // Stop is only honoured at a frame boundary.
                        if (!enable) begin
                            state_d = IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase
    end

    // Frame-level latches and output stage
    always_comb begin
        mode_d      = frame_first ? mode : mode_q;
        solid_d     = frame_first ? solid_val : solid_q;
        frame_cnt_d = frame_cnt_q + {15'd0, frame_first};

        vsync_d = (running && (v_cnt_q < V_SYNC_C)) ? SYNC_ACT : SYNC_INA;
        hsync_d = (running && (h_cnt_q < H_SYNC_C)) ? SYNC_ACT : SYNC_INA;
        valid_d = active;
        data_d  = pix;
        x_d     = active ? x_cur : '0;
        y_d     = active ? y_cur : '0;
        fs_d    = frame_first;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            mode_q      <= MODE_EXT;
            solid_q     <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= SYNC_INA;
            hsync_q     <= SYNC_INA;
            valid_q     <= 1'b0;
            data_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fs_q        <= fs_d;
        end
    end

    assign img_vsync   = vsync_q;
    assign img_hsync   = hsync_q;
    assign img_valid   = valid_q;
    assign img_data    = data_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_src.sv
// Scoreboard bench for video_timing_src on a 15x7 raster (105 cycles/frame).
module tb_video_timing_src;

    localparam int DW = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] solid_val = '0;
    logic [DW-1:0] ext_data = '0;

    logic          data_req, img_vsync, img_hsync, img_valid, frame_start;
    logic [DW-1:0] img_data;
    logic [CW-1:0] x_pos, y_pos;
    logic [15:0]   frame_cnt;

    logic          z_req, z_vsync, z_hsync, z_valid, z_fs;
    logic [DW-1:0] z_data;
    logic [CW-1:0] z_x, z_y;
    logic [15:0]   z_fcnt;

    video_timing_src #(
        .DATA_W(DW), .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .SYNC_POL(1), .CHK_SHIFT(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .solid_val(solid_val), .ext_data(ext_data), .data_req(data_req),
        .img_vsync(img_vsync), .img_hsync(img_hsync), .img_valid(img_valid),
        .img_data(img_data), .x_pos(x_pos), .y_pos(y_pos),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // Low-active sync variant, driven identically.
    video_timing_src #(
        .DATA_W(DW), .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .SYNC_POL(0), .CHK_SHIFT(1), .CNT_W(CW)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .solid_val(solid_val), .ext_data(ext_data), .data_req(z_req),
        .img_vsync(z_vsync), .img_hsync(z_hsync), .img_valid(z_valid),
        .img_data(z_data), .x_pos(z_x), .y_pos(z_y),
        .frame_start(z_fs), .frame_cnt(z_fcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [11:0] x;
        logic [11:0] y;
    } pix_t;

    pix_t exp_q[$];

    int checks = 0;
    int passes = 0;
    bit mon_on = 1'b0;

    int cyc = 0, prev_fs = 0, last_period = 0;
    int n_valid = 0, n_hs = 0, n_vs = 0, n_zhs = 0, n_zvs = 0;
    int l_valid = 0, l_hs = 0, l_vs = 0, l_zhs = 0, l_zvs = 0;

    int  ext_ctr = 0;
    bit  req_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pixel scoreboard plus per-frame statistics.
    always @(negedge clk) begin
        pix_t e;
        cyc++;
        if (frame_start) begin
            last_period = cyc - prev_fs;
            prev_fs = cyc;
            l_valid = n_valid; l_hs = n_hs; l_vs = n_vs; l_zhs = n_zhs; l_zvs = n_zvs;
            n_valid = 0; n_hs = 0; n_vs = 0; n_zhs = 0; n_zvs = 0;
        end
        n_valid += int'(img_valid);
        n_hs    += int'(img_hsync == 1'b1);
        n_vs    += int'(img_vsync == 1'b1);
        n_zhs   += int'(z_hsync == 1'b0);
        n_zvs   += int'(z_vsync == 1'b0);
        if (mon_on) begin
            if (img_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", {24'd0, img_data}, {24'd0, e.d});
                    chk("pix_xy", {8'd0, x_pos, y_pos}, {8'd0, e.x, e.y});
                end
            end else begin
                chk("blank_zero", {img_data, x_pos, y_pos}, 32'd0);
            end
        end
    end

    // External pixel source: answers data_req and records what it presented.
    always @(negedge clk) begin
        if (frame_start) ext_ctr = 0;
        if (mon_on && req_prev) chk("req_implies_valid", {31'd0, img_valid}, 32'd1);
        req_prev = data_req;
        if (data_req) begin
            ext_data = 8'(ext_ctr);
            exp_q.push_back('{d: 8'(ext_ctr), x: 12'(ext_ctr % 8), y: 12'(ext_ctr / 8)});
            ext_ctr++;
        end
    end

    task automatic wait_fs(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("fs_timeout", 32'd0, 32'd1);
    endtask

    // At each frame start the settings just latched define the whole frame.
    task automatic on_fs(input int exp_cnt);
        logic [7:0] d;
        chk("frame_cnt", {16'd0, frame_cnt}, exp_cnt);
        chk("sync_at_fs_pol1", {30'd0, img_vsync, img_hsync}, 32'd3);
        chk("sync_at_fs_pol0", {30'd0, z_vsync, z_hsync}, 32'd0);
        if (mode != 2'd0) begin
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 8; x++) begin
                    case (mode)
                        2'd1:    d = 8'(x);
                        2'd2:    d = ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
                        default: d = solid_val;
                    endcase
                    exp_q.push_back('{d: d, x: 12'(x), y: 12'(y)});
                end
            end
        end
    endtask

    task automatic check_stats();
        chk("frame_period", last_period, 32'd105);
        chk("valid_per_frame", l_valid, 32'd32);
        chk("hsync_per_frame", l_hs, 32'd14);
        chk("vsync_per_frame", l_vs, 32'd15);
        chk("hsync_low_pol0", l_zhs, 32'd14);
        chk("vsync_low_pol0", l_zvs, 32'd15);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {29'd0, img_valid, data_req, frame_start}, 32'd0);
        chk({tag, "_data"}, {24'd0, img_data}, 32'd0);
        chk({tag, "_xy"}, {8'd0, x_pos, y_pos}, 32'd0);
        chk({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'd0);
        chk({tag, "_sync"}, {28'd0, img_vsync, img_hsync, z_vsync, z_hsync}, 32'b0011);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        mon_on = 1'b1;

        // Gradient frames
        @(negedge clk); #1;
        rst_n = 1'b1; mode = 2'd1; enable = 1'b1;
        wait_fs(10);  on_fs(1);
        wait_fs(200); check_stats(); on_fs(2);
        mode = 2'd0;
        // External data frame
        wait_fs(200); check_stats(); on_fs(3);
        mode = 2'd2;
        // Checkerboard, then solid
        wait_fs(200); check_stats(); on_fs(4);
        mode = 2'd3; solid_val = 8'h5A;
        wait_fs(200); check_stats(); on_fs(5);
        mode = 2'd1;
        // Mid-frame mode change must wait for the next frame
        wait_fs(200); check_stats(); on_fs(6);
        repeat (36) @(negedge clk);
        #1 mode = 2'd3;
        wait_fs(200); check_stats(); on_fs(7);
        // Stop request mid-frame: frame must complete
        repeat (39) @(negedge clk);
        #1 enable = 1'b0;
        repeat (120) @(negedge clk);
        #1;
        chk("stop_frame_complete", exp_q.size(), 32'd0);
        chk("stop_frame_valid", n_valid, 32'd32);
        chk("stop_frame_hsync", n_hs, 32'd14);
        chk("stop_frame_vsync", n_vs, 32'd15);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            chk("idle_outputs", {25'd0, img_valid, img_vsync, img_hsync, z_vsync, z_hsync,
                                 frame_start, data_req}, 32'b0001100);
            chk("idle_fcnt", {16'd0, frame_cnt}, 32'd7);
        end

        // Restart: frame_start two sampled cycles after enable
        mode = 2'd1; enable = 1'b1;
        @(negedge clk); #1;
        chk("restart_no_fs_yet", {31'd0, frame_start}, 32'd0);
        @(negedge clk); #1;
        chk("restart_fs", {31'd0, frame_start}, 32'd1);
        on_fs(8);

        // Reset in the middle of an active line
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (img_valid) break;
        end
        chk("reach_active", {31'd0, img_valid}, 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0; enable = 1'b0;
        @(negedge clk); #1;
        exp_q.delete();
        check_reset_vals("midline_reset");
        @(negedge clk); #1;
        rst_n = 1'b1; enable = 1'b1; mode = 2'd1;
        wait_fs(10); on_fs(1);
        enable = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        chk("post_reset_frame_done", exp_q.size(), 32'd0);
        chk("post_reset_fcnt", {16'd0, frame_cnt}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
